// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer in front of an I2C master controller.
// Host commands are buffered in a small FIFO; a four-state FSM issues them
// one at a time, waits for the controller to go busy and then idle again,
// and returns a one-cycle response carrying read data or a timeout flag.
module i2c_cmd_sequencer #(
   parameter int DEPTH        = 4,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [6:0]               cmd_address_i,
   input  logic                     cmd_rw_i,
   input  logic [7:0]               cmd_register_i,
   input  logic [7:0]               cmd_data_i,
   output logic [6:0]               address_o,
   output logic                     rw_o,
   output logic [7:0]               register_o,
   output logic [7:0]               data_o,
   output logic                     execute_o,
   input  logic                     busy_i,
   input  logic [7:0]               rdata_i,
   output logic                     rsp_valid_o,
   output logic [7:0]               rsp_data_o,
   output logic                     rsp_error_o,
   output logic [$clog2(DEPTH):0]   pending_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
   localparam logic [TMO_W-1:0] TIMEOUT_CNT = TMO_W'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE,
      RESPOND
   } state_t;

   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] reg_addr;
      logic [7:0] data;
   } cmd_t;

   cmd_t             mem [DEPTH];
   cmd_t             cmd_in;
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             queued;
   logic             push;
   logic             pop;
   logic             timeout;
   logic [TMO_W-1:0] tmo_cnt;
   state_t           state;
   state_t           next_state;

   assign cmd_in      = '{addr: cmd_address_i, rw: cmd_rw_i, reg_addr: cmd_register_i, data: cmd_data_i};
   assign head        = mem[rd_ptr];
   assign pending_o   = count;
   assign cmd_ready_o = (count < DEPTH_CNT);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign timeout     = (tmo_cnt == TIMEOUT_CNT);

   // Queue storage: an entry is written only on an accepted push.
   // NOTE: the storage array is deliberately not reset; the pointers and count
   // alone define which entries are valid, so stale contents are never read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= cmd_in;
      end
   end

   // Queue pointers, occupancy count and the registered non-empty flag.
   // The FSM launches from the registered flag, so a command pushed into an
   // empty queue waits one extra cycle before the pop.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         queued <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         queued <= (count != '0);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic and pop strobe.
   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (queued) begin
               pop        = 1'b1;
               next_state = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (busy_i) begin
               next_state = WAIT_DONE;
            end else if (timeout) begin
               next_state = RESPOND;
            end
         end
         WAIT_DONE: begin
            if (!busy_i) begin
               next_state = RESPOND;
            end
         end
         RESPOND: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Controller-facing outputs, timeout counter and response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         address_o   <= '0;
         rw_o        <= 1'b0;
         register_o  <= '0;
         data_o      <= '0;
         execute_o   <= 1'b0;
         tmo_cnt     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_error_o <= 1'b0;
      end else begin
         execute_o   <= (next_state == WAIT_BUSY);
         rsp_valid_o <= (next_state == RESPOND);

         if (pop) begin
            address_o  <= head.addr;
            rw_o       <= head.rw;
            register_o <= head.reg_addr;
            data_o     <= head.data;
            tmo_cnt    <= '0;
         end else if (state == WAIT_BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if ((state == WAIT_BUSY) && !busy_i && timeout) begin
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b1;
         end else if ((state == WAIT_DONE) && !busy_i) begin
            rsp_data_o  <= rw_o ? rdata_i : 8'h00;
            rsp_error_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: a command-queue model, a
// behavioural I2C controller model and an in-order response scoreboard.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

   localparam int DEPTH        = 4;
   localparam int BUSY_TIMEOUT = 255;
   localparam int PW           = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] reg_addr;
      logic [7:0] data;
   } cmd_t;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } rsp_t;

   logic          clk;
   logic          rst       = 1'b1;
   logic          drv_valid = 1'b0;
   cmd_t          drv       = '0;
   logic          busy      = 1'b0;
   logic [7:0]    rdata     = 8'h00;

   logic          cmd_ready_o;
   logic [6:0]    address_o;
   logic          rw_o;
   logic [7:0]    register_o;
   logic [7:0]    data_o;
   logic          execute_o;
   logic          rsp_valid_o;
   logic [7:0]    rsp_data_o;
   logic          rsp_error_o;
   logic [PW-1:0] pending_o;

   i2c_cmd_sequencer #(
      .DEPTH        (DEPTH),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cmd_valid_i    (drv_valid),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_address_i  (drv.addr),
      .cmd_rw_i       (drv.rw),
      .cmd_register_i (drv.reg_addr),
      .cmd_data_i     (drv.data),
      .address_o      (address_o),
      .rw_o           (rw_o),
      .register_o     (register_o),
      .data_o         (data_o),
      .execute_o      (execute_o),
      .busy_i         (busy),
      .rdata_i        (rdata),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_data_o     (rsp_data_o),
      .rsp_error_o    (rsp_error_o),
      .pending_o      (pending_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int   checks        = 0;
   int   failures      = 0;
   int   cyc           = 0;

   // Reference model state
   cmd_t m_q[$];
   rsp_t r_q[$];
   cmd_t cur           = '0;
   logic in_flight     = 1'b0;
   int   exec_len      = 0;
   int   exp_exec_len  = 0;
   logic exec_prev     = 1'b0;
   logic rsp_prev      = 1'b0;
   rsp_t hold          = '0;
   int   last_rise_cyc = -100;
   int   last_rsp_cyc  = -100;
   int   simul         = 0;

   // Controller model configuration and state
   logic       ctl_rand    = 1'b0;
   logic       ctl_dead    = 1'b0;
   logic       ctl_force   = 1'b0;
   logic       ctl_active  = 1'b0;
   logic       ctl_fix     = 1'b0;
   logic [7:0] ctl_fix_val = 8'h00;
   logic [7:0] ctl_rdata   = 8'h00;
   int         ctl_dly     = 2;
   int         ctl_hold    = 20;
   int         ctl_t       = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.addr     = 7'($urandom);
      c.rw       = 1'($urandom);
      c.reg_addr = 8'($urandom);
      c.data     = 8'($urandom);
      return c;
   endfunction

   // One clock cycle: observe the DUT at the falling edge, advance the models,
   // then update the controller model's drive for the next rising edge.
   task automatic step();
      logic rise;
      logic fall;
      logic took;
      @(negedge clk);
      cyc++;

      if (rst) begin
         m_q.delete();
         r_q.delete();
         in_flight  = 1'b0;
         ctl_active = 1'b0;
         hold       = '0;
         check("rst_execute",   32'(execute_o), 0);
         check("rst_rsp_valid", 32'(rsp_valid_o), 0);
         check("rst_outputs",   32'({address_o, rw_o, register_o, data_o}), 0);
         check("rst_pending",   32'(pending_o), 0);
         check("rst_rsp_regs",  32'({rsp_error_o, rsp_data_o}), 0);
         exec_prev = execute_o;
         rsp_prev  = rsp_valid_o;
         return;
      end

      took = drv_valid && (m_q.size() < DEPTH);
      rise = execute_o && !exec_prev;
      fall = !execute_o && exec_prev;

      if (rise) begin
         check("pop_nonempty", 32'(m_q.size() != 0), 1);
         if (m_q.size() != 0) begin
            cur = m_q.pop_front();
            check("cmd_out",  32'({address_o, rw_o, register_o, data_o}), 32'(cur));
            check("idle_gap", 32'((cyc - last_rsp_cyc) >= 2), 1);
            if (took) simul++;
            last_rise_cyc = cyc;
            in_flight     = 1'b1;
            exec_len      = 0;
            if (ctl_rand) begin
               ctl_dly  = $urandom_range(1, 4);
               ctl_hold = $urandom_range(1, 6);
               ctl_dead = ($urandom_range(0, 7) == 0);
            end
            ctl_rdata = ctl_fix ? ctl_fix_val : 8'($urandom);
            if (ctl_dead) begin
               exp_exec_len = BUSY_TIMEOUT + 1;
               r_q.push_back(rsp_t'{1'b1, 8'h00});
            end else begin
               exp_exec_len = ctl_force ? 1 : ctl_dly + 1;
               r_q.push_back(rsp_t'{1'b0, cur.rw ? ctl_rdata : 8'h00});
               ctl_active = !ctl_force;
               ctl_t      = 0;
            end
         end
      end else if (in_flight) begin
         check("cmd_stable", 32'({address_o, rw_o, register_o, data_o}), 32'(cur));
      end

      if (took) m_q.push_back(drv);
      check("pending", 32'(pending_o), 32'(m_q.size()));
      check("ready",   32'(cmd_ready_o), 32'(m_q.size() < DEPTH));

      if (in_flight && execute_o) exec_len++;
      if (fall) begin
         check("fall_in_flight", 32'(in_flight), 1);
         check("exec_len", 32'(exec_len), 32'(exp_exec_len));
      end

      if (rsp_valid_o) begin
         check("rsp_expected", 32'(r_q.size() != 0), 1);
         check("rsp_single",   32'(rsp_prev), 0);
         if (r_q.size() != 0) hold = r_q.pop_front();
         in_flight    = 1'b0;
         last_rsp_cyc = cyc;
      end
      check("rsp_hold", 32'({rsp_error_o, rsp_data_o}), 32'(hold));

      exec_prev = execute_o;
      rsp_prev  = rsp_valid_o;

      if (ctl_dead) begin
         busy = 1'b0;
      end else if (ctl_force) begin
         busy = 1'b1;
      end else if (ctl_active) begin
         if (ctl_t == ctl_dly) begin
            busy  = 1'b1;
            rdata = 8'($urandom);
         end
         if (ctl_t == ctl_dly + ctl_hold) begin
            busy       = 1'b0;
            rdata      = ctl_rdata;
            ctl_active = 1'b0;
         end
         ctl_t++;
      end
   endtask

   task automatic push_cmd(input cmd_t c);
      drv       = c;
      drv_valid = 1'b1;
      step();
      drv_valid = 1'b0;
   endtask

   task automatic wait_rise(input int p);
      for (int i = 0; i < 10 && last_rise_cyc < p; i++) step();
      check("latency", 32'(last_rise_cyc - p), 2);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((m_q.size() != 0 || r_q.size() != 0 || in_flight) && n < budget) begin
         step();
         n++;
      end
      check("drained", 32'(m_q.size() == 0 && r_q.size() == 0 && !in_flight), 1);
      step();
      step();
   endtask

   task automatic release_force();
      ctl_force = 1'b0;
      busy      = 1'b0;
      rdata     = ctl_rdata;
   endtask

   initial begin
      int p;
      int arm;
      int pushes_left;

      // Reset and release
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      step();
      check("ready_after_reset", 32'(cmd_ready_o), 1);

      // Write transaction with push-to-execute latency
      ctl_dly  = 2;
      ctl_hold = 20;
      push_cmd(cmd_t'{7'h78, 1'b0, 8'h0F, 8'h55});
      p = cyc;
      wait_rise(p);
      wait_idle(100);
      check("write_rsp", 32'({rsp_error_o, rsp_data_o}), 0);

      // Read transaction returning 0xA5
      ctl_fix     = 1'b1;
      ctl_fix_val = 8'hA5;
      push_cmd(cmd_t'{7'h78, 1'b1, 8'h0F, 8'($urandom)});
      wait_idle(100);
      check("read_rsp_data", 32'(rsp_data_o), 32'h00A5);
      check("read_rsp_err",  32'(rsp_error_o), 0);
      ctl_fix = 1'b0;

      // Busy never rises: timeout with zero data even for a read
      ctl_dead = 1'b1;
      rdata    = 8'h3C;
      push_cmd(cmd_t'{7'h22, 1'b1, 8'h10, 8'h00});
      wait_idle(BUSY_TIMEOUT + 50);
      check("timeout_err",  32'(rsp_error_o), 1);
      check("timeout_data", 32'(rsp_data_o), 0);
      ctl_dead = 1'b0;

      // Full queue behind a transaction stuck in WAIT_DONE
      ctl_force = 1'b1;
      push_cmd(rand_cmd());
      for (int i = 0; i < 3; i++) step();
      for (int i = 0; i < 5; i++) begin
         drv       = rand_cmd();
         drv_valid = 1'b1;
         step();
      end
      drv_valid = 1'b0;
      check("full_pending", 32'(pending_o), 4);
      check("full_ready",   32'(cmd_ready_o), 0);
      step();
      ctl_dly  = 1;
      ctl_hold = 3;
      release_force();
      simul       = 0;
      arm         = 0;
      pushes_left = 2;
      for (int i = 0; i < 300 && (m_q.size() != 0 || r_q.size() != 0 || in_flight || arm != 0); i++) begin
         step();
         drv_valid = 1'b0;
         if (arm == 1) begin
            drv       = rand_cmd();
            drv_valid = 1'b1;
         end
         if (arm > 0) arm--;
         if (rsp_valid_o && m_q.size() != 0 && m_q.size() < DEPTH && pushes_left > 0) begin
            arm = 1;
            pushes_left--;
         end
      end
      drv_valid = 1'b0;
      wait_idle(200);
      check("push_pop_same_edge", 32'(simul), 2);

      // Reset while in WAIT_DONE with two commands queued
      ctl_force = 1'b1;
      push_cmd(rand_cmd());
      for (int i = 0; i < 3; i++) step();
      push_cmd(rand_cmd());
      push_cmd(rand_cmd());
      step();
      check("pre_reset_pending", 32'(pending_o), 2);
      rst       = 1'b1;
      ctl_force = 1'b0;
      busy      = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("ready_after_release", 32'(cmd_ready_o), 1);
      for (int i = 0; i < 5; i++) step();
      ctl_dly  = 2;
      ctl_hold = 4;
      push_cmd(cmd_t'{7'h50, 1'b1, 8'hA0, 8'h00});
      wait_idle(100);

      // Randomized traffic with randomized controller timing and timeouts
      ctl_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         drv       = rand_cmd();
         drv_valid = ($urandom_range(0, 99) < 35);
         step();
      end
      drv_valid = 1'b0;
      wait_idle(6000);
      ctl_rand = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
